// File: rtl/inst_rom.sv
// inst_rom: loadable instruction ROM.
// A byte-serial loader fills the array big-endian, one 32-bit word per
// four accepted bytes; once the image is finished (RUN) the core fetches
// with zero latency. Outside RUN, or for out-of-range/disabled fetches,
// the read port returns a NOP (32'h0).
// Optional feature: define INST_ROM_CHKSUM_EN to add a 32-bit running
// sum of all words written in the current load on output chksum.
module inst_rom #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           inst,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    output logic                  ld_ready,
    input  logic                  ld_done,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   word_cnt,
    output logic                  err
`ifdef INST_ROM_CHKSUM_EN
    ,
    output logic [31:0]           chksum
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [1:0]            byte_cnt;
    logic [1:0]            byte_cnt_nxt;
    logic [23:0]           asm_q;        // first three bytes of the word in flight
    logic [DEPTH_LOG2:0]   word_cnt_q;
    logic                  err_q;
    logic [31:0]           mem [DEPTH];

    logic                  in_load;
    logic                  full;
    logic                  xfer;
    logic                  last_byte;
    logic                  wr_en;
    logic [31:0]           wr_word;
    logic                  rd_hit;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  unused_addr_lsb;

    // Loader handshake and word assembly. The write pointer is word_cnt
    // itself; its MSB alone flags a full array since it never exceeds DEPTH.
    assign in_load   = (state == S_LOAD);
    assign full      = word_cnt_q[DEPTH_LOG2];
    assign ld_ready  = in_load && !full;
    assign xfer      = ld_valid && ld_ready;
    assign last_byte = xfer && (byte_cnt == 2'd3);
    assign wr_word   = {asm_q, ld_byte};
    // A restart or reset on the same edge wins over a completing word.
    assign wr_en     = last_byte && !rst && !ld_start;

    assign busy     = in_load;
    assign word_cnt = word_cnt_q;
    assign err      = err_q;

    // Byte position after this cycle; wraps 3 -> 0 when a word completes.
    always_comb begin
        byte_cnt_nxt = byte_cnt;
        if (xfer) begin
            byte_cnt_nxt = byte_cnt + 2'd1;
        end
    end

    // Next-state: ld_start restarts from anywhere; ld_done only ends a LOAD.
    always_comb begin
        state_nxt = state;
        if (ld_start) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_LOAD:  if (ld_done) state_nxt = S_RUN;
                S_RUN:   state_nxt = S_RUN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Control state, assembly register, word counter and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_cnt   <= 2'd0;
            asm_q      <= 24'h0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (ld_start) begin
            state      <= S_LOAD;
            byte_cnt   <= 2'd0;
            asm_q      <= 24'h0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_load) begin
                byte_cnt <= byte_cnt_nxt;
                if (xfer) begin
                    asm_q <= {asm_q[15:0], ld_byte};
                end
                if (last_byte) begin
                    word_cnt_q <= word_cnt_q + (DEPTH_LOG2 + 1)'(1);
                end
                // Byte offered while the array is full is dropped.
                if (ld_valid && full) begin
                    err_q <= 1'b1;
                end
                // Image ended mid-word: the partial bytes are discarded.
                if (ld_done) begin
                    byte_cnt <= 2'd0;
                    if (byte_cnt_nxt != 2'd0) begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end

    // Array write; deliberately unreset so the image survives a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word_cnt_q[DEPTH_LOG2-1:0]] <= wr_word;
        end
    end

    // Zero-latency fetch; byte offset bits are don't-care.
    assign rd_idx          = addr[DEPTH_LOG2+1:2];
    assign rd_hit          = (state == S_RUN) && ce && (addr[31:DEPTH_LOG2+2] == '0);
    assign unused_addr_lsb = ^addr[1:0];

    // Read mux: NOP unless a valid in-range fetch in RUN.
    always_comb begin
        inst = 32'h0;
        if (rd_hit) begin
            inst = mem[rd_idx];
        end
    end

`ifdef INST_ROM_CHKSUM_EN
    logic [31:0] chksum_q;

    assign chksum = chksum_q;

    // Running modulo-2^32 sum of words written during the current load.
    always_ff @(posedge clk) begin
        if (rst || ld_start) begin
            chksum_q <= 32'h0;
        end else if (wr_en) begin
            chksum_q <= chksum_q + wr_word;
        end
    end
`endif

endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of word capacity (1024 words).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ce  input  1  fetch enable from core pc_reg.
REQ-005 SHALL have port addr  input  32  fetch byte address from core.
REQ-006 SHALL have port inst  output  32  fetched instruction word to core.
REQ-007 SHALL have port ld_start  input  1  pulse; begin (or restart) image load.
REQ-008 SHALL have port ld_valid  input  1  loader byte valid.
REQ-009 SHALL have port ld_byte  input  8  loader byte data.
REQ-010 SHALL have port ld_ready  output  1  block accepts loader byte this cycle.
REQ-011 SHALL have port ld_done  input  1  pulse; end of image.
REQ-012 SHALL have port busy  output  1  high while in LOAD.
REQ-013 SHALL have port word_cnt  output  DEPTH_LOG2+1  words written in current/last load.
REQ-014 SHALL have port err  output  1  sticky: overflow or partial trailing word in last load.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN; IDLE after reset.
REQ-016 SHALL go to LOAD from any state on ld_start, clearing write pointer, byte counter, word_cnt, err.
REQ-017 SHALL go LOAD->RUN on ld_done when ld_start is low; ld_start wins if both asserted.
REQ-018 SHALL drive ld_ready = (state==LOAD) and (word_cnt < 2^DEPTH_LOG2), combinationally.
REQ-019 SHALL transfer a byte only when ld_valid and ld_ready are both high in the same cycle.
REQ-020 SHALL assemble bytes big-endian: 1st byte -> bits 31:24, 4th byte -> bits 7:0.
REQ-021 SHALL write the assembled word to mem[word_cnt] on the cycle of the 4th byte transfer, and increment word_cnt on that same edge.
REQ-022 SHALL accept a 4th byte and a concurrent ld_done on the same cycle: the word is written, then RUN is entered.
REQ-023 SHALL set err when ld_valid is high with state LOAD and the memory full (byte dropped), and when ld_done arrives with byte counter != 0 (partial word discarded, not written).
REQ-024 SHALL drive inst = mem[addr[DEPTH_LOG2+1:2]] combinationally (zero-latency, same cycle as addr) when state==RUN, ce==1, addr[31:DEPTH_LOG2+2]==0.
REQ-025 SHALL drive inst = 32'h0 (NOP) in all other cases, including IDLE, LOAD, ce==0, out-of-range addr; addr[1:0] ignored.
REQ-026 SHALL ignore ld_valid and ld_byte outside LOAD; ld_done outside LOAD has no effect.
REQ-027 SHALL keep word_cnt and err stable in RUN until the next ld_start.

Reset
REQ-028 SHALL, when rst is high at a clock edge, enter IDLE and clear byte counter, write pointer, word_cnt=0, err=0; hence ld_ready=0, busy=0, inst=0.
REQ-029 SHALL abort a load in progress on reset mid-LOAD; partial assembly register discarded.
REQ-030 SHALL NOT clear memory contents on reset; rst overrides ld_start in the same cycle.

Configuration
REQ-031 SHALL, with macro INST_ROM_CHKSUM_EN defined, add output chksum (32 bits) = modulo-2^32 sum of all words written in the current load, cleared by rst and ld_start, updated on the same edge as each word write.
REQ-032 SHALL, without INST_ROM_CHKSUM_EN, have no chksum port and no summing logic; all other behaviour identical.

Verification
REQ-033 SHALL cover: reset, ld_start, bytes 34 01 00 01, 34 02 00 02, ld_done; then ce=1 addr=0x0 -> inst=0x34010001, addr=0x4 -> 0x34020002, word_cnt=2, err=0 (chksum=0x68030003 if enabled).
REQ-034 SHALL cover: in RUN, ce=0 addr=0x0 -> inst=0; addr=0x4000 with DEPTH_LOG2=10 -> inst=0; addr=0x3 -> same as addr=0x0.
REQ-035 SHALL cover: 6 bytes then ld_done -> word_cnt=1, err=1, mem[1] unchanged, state RUN.
REQ-036 SHALL cover: DEPTH_LOG2=2, 20 bytes with ld_valid held high -> ld_ready low after 16th byte, word_cnt=4, err=1, mem[0..3] from first 16 bytes.
REQ-037 SHALL cover: rst asserted after 2 bytes of a load -> next cycle busy=0, ld_ready=0, word_cnt=0; fetch returns 0 until a new load completes.
REQ-038 SHALL cover: 4th byte with ld_done same cycle -> word written, word_cnt=1, RUN next cycle; ld_start with ld_done same cycle -> LOAD, word_cnt=0.
